// File: rtl/count_binary_led_fader_pkg.sv
// Shared constants and types for the LED fader: register map, reset values, channel states.
package count_binary_led_fader_pkg;

  localparam logic [1:0] ADDR_PRESCALE = 2'd0;
  localparam logic [1:0] ADDR_FADE     = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam logic [15:0] PRESCALE_RST = 16'd195;
  localparam logic [15:0] FADE_DIV_RST = 16'd3;
  localparam logic [7:0]  STEP_RST     = 8'd1;
  localparam logic [1:0]  CTRL_RST     = 2'b01;

  localparam int unsigned CTRL_ENABLE_BIT = 0;
  localparam int unsigned CTRL_BYPASS_BIT = 1;

  typedef enum logic [1:0] {ChOff, ChRising, ChOn, ChFalling} ch_state_e;

endpackage

// File: rtl/count_binary_led_fader_if.sv
// Avalon-MM slave bus for the fader configuration/status registers.
interface count_binary_led_fader_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/count_binary_led_fader_channel.sv
// One LED channel: brightness level that ramps toward its on/off target, plus PWM output flop.
module count_binary_led_fader_channel
  import count_binary_led_fader_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                target_i,
  input  logic [7:0]          step_i,
  input  logic                fade_tick_i,
  input  logic                run_i,
  input  logic                enable_i,
  input  logic                bypass_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic                led_o,
  output logic                busy_o
);

  localparam int unsigned W = PWM_BITS + 1;
  localparam logic [PWM_BITS-1:0] LevelMax = '1;

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;
  logic [W-1:0]        step_ext, sum;
  ch_state_e           state;

  // Channel state is derived from the current level and target, not stored.
  always_comb begin
    state = ChOff;
    if (target_i) state = (level_q == LevelMax) ? ChOn : ChRising;
    else          state = (level_q == '0) ? ChOff : ChFalling;
  end

  // Level next-state: instant jump when STEP is 0, else saturating step on each fade tick.
  always_comb begin
    level_d  = level_q;
    step_ext = W'(step_i);
    sum      = {1'b0, level_q} + step_ext;
    if (run_i && (step_i == 8'd0)) begin
      level_d = target_i ? LevelMax : '0;
    end else if (fade_tick_i) begin
      case (state)
        ChRising:  level_d = sum[PWM_BITS] ? LevelMax : sum[PWM_BITS-1:0];
        ChFalling: level_d = ({1'b0, level_q} > step_ext) ?
                             (level_q - step_ext[PWM_BITS-1:0]) : '0;
        default:   level_d = level_q;
      endcase
    end
  end

  // Output select: bypass passes the target straight through, otherwise compare against PWM.
  always_comb begin
    led_d = 1'b0;
    if (bypass_i)      led_d = target_i;
    else if (enable_i) led_d = (level_q == LevelMax) | (level_q > pwm_cnt_i);
  end

  // Level and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = (state == ChRising) || (state == ChFalling);

endmodule

// File: rtl/count_binary_led_fader.sv
// LED fader top: register file, prescaler, PWM counter, fade divider and per-LED channels.
module count_binary_led_fader
  import count_binary_led_fader_pkg::*;
#(
  parameter int unsigned N_LEDS   = 8,
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_LEDS-1:0]      led_in,
  count_binary_led_fader_if.slave bus,
  output logic [N_LEDS-1:0]      led_out
);

  logic [15:0]         prescale_q, prescale_d;
  logic [15:0]         fade_div_q, fade_div_d;
  logic [7:0]          step_q, step_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [15:0]         pre_cnt_q, pre_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [15:0]         fade_cnt_q, fade_cnt_d;
  logic                we, run, pwm_tick, pwm_wrap, fade_tick;
  logic [N_LEDS-1:0]   busy;
  logic [31:0]         rdata;

  assign we = bus.chipselect && !bus.write_n;
  // Bypass keeps the timebase running so levels follow the targets while bypassed.
  assign run = ctrl_q[CTRL_ENABLE_BIT] | ctrl_q[CTRL_BYPASS_BIT];

  // Register file write decode; STATUS writes are ignored.
  always_comb begin
    prescale_d = prescale_q;
    fade_div_d = fade_div_q;
    step_d     = step_q;
    ctrl_d     = ctrl_q;
    if (we) begin
      case (bus.address)
        ADDR_PRESCALE: prescale_d = bus.writedata[15:0];
        ADDR_FADE: begin
          fade_div_d = bus.writedata[15:0];
          step_d     = bus.writedata[23:16];
        end
        ADDR_CTRL: ctrl_d = bus.writedata[1:0];
        default: ;
      endcase
    end
  end

  // Prescaler, PWM counter and fade divider; >= lets a shrunk limit wrap immediately.
  always_comb begin
    pwm_tick   = run && (pre_cnt_q >= prescale_q);
    pwm_wrap   = pwm_tick && (pwm_cnt_q == '1);
    fade_tick  = pwm_wrap && (fade_cnt_q >= fade_div_q);
    pre_cnt_d  = pre_cnt_q;
    pwm_cnt_d  = pwm_cnt_q;
    fade_cnt_d = fade_cnt_q;
    if (run) pre_cnt_d = pwm_tick ? 16'd0 : pre_cnt_q + 16'd1;
    if (pwm_tick) pwm_cnt_d = pwm_cnt_q + 1'b1;
    if (pwm_wrap) fade_cnt_d = fade_tick ? 16'd0 : fade_cnt_q + 16'd1;
  end

  // Zero-latency read mux.
  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_PRESCALE: rdata[15:0] = prescale_q;
      ADDR_FADE:     rdata[23:0] = {step_q, fade_div_q};
      ADDR_CTRL:     rdata[1:0]  = ctrl_q;
      default: begin
        rdata[N_LEDS-1:0]  = led_in;
        rdata[8 +: N_LEDS] = busy;
      end
    endcase
  end

  assign bus.readdata = rdata;

  // Configuration and timebase state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale_q <= PRESCALE_RST;
      fade_div_q <= FADE_DIV_RST;
      step_q     <= STEP_RST;
      ctrl_q     <= CTRL_RST;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      fade_cnt_q <= '0;
    end else begin
      prescale_q <= prescale_d;
      fade_div_q <= fade_div_d;
      step_q     <= step_d;
      ctrl_q     <= ctrl_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      fade_cnt_q <= fade_cnt_d;
    end
  end

  for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
    count_binary_led_fader_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .target_i   (led_in[i]),
      .step_i     (step_q),
      .fade_tick_i(fade_tick),
      .run_i      (run),
      .enable_i   (ctrl_q[CTRL_ENABLE_BIT]),
      .bypass_i   (ctrl_q[CTRL_BYPASS_BIT]),
      .pwm_cnt_i  (pwm_cnt_q),
      .led_o      (led_out[i]),
      .busy_o     (busy[i])
    );
  end

endmodule

// File: tb/tb_count_binary_led_fader.sv
// Self-checking bench for count_binary_led_fader: expected values queued, popped at compare time.
module tb_count_binary_led_fader;
  import count_binary_led_fader_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] led_in;
  logic [7:0] led_out;

  count_binary_led_fader_if bus ();

  count_binary_led_fader #(
    .N_LEDS  (8),
    .PWM_BITS(8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .led_in (led_in),
    .bus    (bus),
    .led_out(led_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp;

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    #1 d = bus.readdata;
  endtask

  task automatic do_reset();
    reset = 1'b1; led_in = 8'h00;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Waits for led_out[0] to go high; returns 0 on timeout.
  task automatic wait_rise(output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 3000 && !hit; i++) begin
      @(negedge clk);
      if (led_out[0]) hit = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    bus_write(ADDR_PRESCALE, 32'd5);
    bus_write(ADDR_FADE, 32'h0020_0007);
    bus_write(ADDR_CTRL, 32'd3);
    led_in = 8'hFF;
    repeat (20) @(negedge clk);
    exp_q.push_back(32'h0);
    #2 reset = 1'b1;
    #1;
    exp = exp_q.pop_front(); checks++;
    if (led_out !== exp[7:0]) begin
      errors++; $display("FAIL reset_async_led_out: got %h expected %h", led_out, exp[7:0]);
    end
    led_in = 8'h00;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(32'd195);
    exp_q.push_back(32'h0001_0003);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h0);
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], rd);
      exp = exp_q.pop_front(); checks++;
      if (rd !== exp) begin
        errors++; $display("FAIL reset_reg%0d: got %h expected %h", a, rd, exp);
      end
    end
    led_in = 8'h81;
    exp_q.push_back(32'h8181);
    bus_read(ADDR_STATUS, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin
      errors++; $display("FAIL reset_status_busy: got %h expected %h", rd, exp);
    end
    exp_q.push_back(32'h0);
    exp = exp_q.pop_front(); checks++;
    if (led_out !== exp[7:0]) begin
      errors++; $display("FAIL reset_led_out: got %h expected %h", led_out, exp[7:0]);
    end
  endtask

  task automatic test_rise();
    bit hit;
    int ones;
    do_reset();
    bus_write(ADDR_PRESCALE, 32'd0);
    bus_write(ADDR_FADE, 32'h0040_0000);
    bus.address = ADDR_STATUS;
    led_in = 8'h01;
    // window duties, busy mid-third window, final duty, busy at end
    exp_q.push_back(32'd64); exp_q.push_back(32'd128); exp_q.push_back(32'd1);
    exp_q.push_back(32'd192); exp_q.push_back(32'd256); exp_q.push_back(32'd0);
    wait_rise(hit);
    if (!hit) begin
      checks++; errors++; $display("FAIL rise_start: got timeout expected led_out[0] high");
      exp_q.delete();
      return;
    end
    ones = 0;
    for (int j = 0; j < 1024; j++) begin
      if (j > 0) @(negedge clk);
      if (led_out[0]) ones++;
      if (j == 512) begin
        exp = exp_q.pop_front(); checks++;
        if (bus.readdata[8] !== exp[0]) begin
          errors++; $display("FAIL rise_busy_mid: got %b expected %b", bus.readdata[8], exp[0]);
        end
      end
      if (j % 256 == 255) begin
        exp = exp_q.pop_front(); checks++;
        if (ones !== int'(exp)) begin
          errors++; $display("FAIL rise_duty_w%0d: got %0d expected %0d", j / 256, ones, exp);
        end
        ones = 0;
      end
    end
    exp = exp_q.pop_front(); checks++;
    if (bus.readdata[8] !== exp[0]) begin
      errors++; $display("FAIL rise_busy_end: got %b expected %b", bus.readdata[8], exp[0]);
    end
  endtask

  task automatic test_reversal();
    bit hit;
    int ones;
    do_reset();
    bus_write(ADDR_PRESCALE, 32'd0);
    bus_write(ADDR_FADE, 32'h0040_0000);
    bus.address = ADDR_STATUS;
    led_in = 8'h01;
    exp_q.push_back(32'd64); exp_q.push_back(32'd128); exp_q.push_back(32'h0100);
    exp_q.push_back(32'd64); exp_q.push_back(32'd0); exp_q.push_back(32'h0000);
    wait_rise(hit);
    if (!hit) begin
      checks++; errors++; $display("FAIL rev_start: got timeout expected led_out[0] high");
      exp_q.delete();
      return;
    end
    ones = 0;
    for (int j = 0; j < 1024; j++) begin
      if (j > 0) @(negedge clk);
      if (led_out[0]) ones++;
      if (j == 356) led_in = 8'h00;
      if (j == 522) begin
        exp = exp_q.pop_front(); checks++;
        if (bus.readdata[15:0] !== exp[15:0]) begin
          errors++; $display("FAIL rev_status_mid: got %h expected %h", bus.readdata[15:0], exp[15:0]);
        end
      end
      if (j % 256 == 255) begin
        exp = exp_q.pop_front(); checks++;
        if (ones !== int'(exp)) begin
          errors++; $display("FAIL rev_duty_w%0d: got %0d expected %0d", j / 256, ones, exp);
        end
        ones = 0;
      end
    end
    exp = exp_q.pop_front(); checks++;
    if (bus.readdata[15:0] !== exp[15:0]) begin
      errors++; $display("FAIL rev_status_end: got %h expected %h", bus.readdata[15:0], exp[15:0]);
    end
  endtask

  task automatic test_instant();
    logic [7:0] pats [2];
    int bad;
    pats[0] = 8'hA5; pats[1] = 8'h5A;
    do_reset();
    bus_write(ADDR_FADE, 32'h0000_0003);
    bus.address = ADDR_STATUS;
    for (int p = 0; p < 2; p++) begin
      led_in = pats[p];
      exp_q.push_back({24'h0, pats[p]});
      exp_q.push_back(32'd0);
      exp_q.push_back(32'd0);
      @(negedge clk); @(negedge clk);
      exp = exp_q.pop_front(); checks++;
      if (led_out !== exp[7:0]) begin
        errors++; $display("FAIL instant_first_%0d: got %h expected %h", p, led_out, exp[7:0]);
      end
      bad = 0;
      for (int k = 0; k < 300; k++) begin
        @(negedge clk);
        if (led_out !== pats[p]) bad++;
      end
      exp = exp_q.pop_front(); checks++;
      if (bad !== int'(exp)) begin
        errors++; $display("FAIL instant_steady_%0d: got %0d bad cycles expected %0d", p, bad, exp);
      end
      exp = exp_q.pop_front(); checks++;
      if (bus.readdata[15:8] !== exp[7:0]) begin
        errors++; $display("FAIL instant_busy_%0d: got %h expected %h", p, bus.readdata[15:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_bypass();
    bit hit;
    int ones;
    int bad;
    bit done;
    do_reset();
    bus_write(ADDR_CTRL, 32'd3);
    led_in = 8'h3C;
    exp_q.push_back(32'h00); exp_q.push_back(32'h3C); exp_q.push_back(32'hC3);
    #1;
    exp = exp_q.pop_front(); checks++;
    if (led_out !== exp[7:0]) begin
      errors++; $display("FAIL bypass_before_edge: got %h expected %h", led_out, exp[7:0]);
    end
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (led_out !== exp[7:0]) begin
      errors++; $display("FAIL bypass_latency: got %h expected %h", led_out, exp[7:0]);
    end
    led_in = 8'hC3;
    @(negedge clk);
    exp = exp_q.pop_front(); checks++;
    if (led_out !== exp[7:0]) begin
      errors++; $display("FAIL bypass_follow: got %h expected %h", led_out, exp[7:0]);
    end
    // Freeze/resume: one PWM period at level 128 must still give exactly 128 high cycles.
    led_in = 8'h00;
    bus_write(ADDR_CTRL, 32'd1);
    bus_write(ADDR_PRESCALE, 32'd0);
    bus_write(ADDR_FADE, 32'h0080_0000);
    repeat (4) @(negedge clk);
    led_in = 8'h01;
    exp_q.push_back(32'd0); exp_q.push_back(32'd128);
    wait_rise(hit);
    if (!hit) begin
      checks++; errors++; $display("FAIL freeze_start: got timeout expected led_out[0] high");
      exp_q.delete();
      return;
    end
    ones = 0; bad = 0; done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (i > 0) @(negedge clk);
      if (led_out[0]) ones++;
      if (i >= 52 && i <= 301 && led_out !== 8'h00) bad++;
      if (i > 302 && !led_out[0]) done = 1'b1;
      if (i == 50 || i == 300) begin
        bus.address = ADDR_CTRL; bus.writedata = (i == 300) ? 32'd1 : 32'd0;
        bus.chipselect = 1'b1; bus.write_n = 1'b0;
      end
      if (i == 51 || i == 301) begin
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
      end
    end
    exp = exp_q.pop_front(); checks++;
    if (bad !== int'(exp)) begin
      errors++; $display("FAIL freeze_led_zero: got %0d bad cycles expected %0d", bad, exp);
    end
    exp = exp_q.pop_front(); checks++;
    if (!done || ones !== int'(exp)) begin
      errors++; $display("FAIL freeze_resume_duty: got %0d (done=%0b) expected %0d", ones, done, exp);
    end
  endtask

  task automatic test_prescale_shrink();
    bit hit;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (dut.pre_cnt_q == 16'd100) hit = 1'b1;
    end
    if (!hit) begin
      checks++; errors++; $display("FAIL shrink_sync: got timeout expected pre_cnt 100");
      return;
    end
    bus.address = ADDR_PRESCALE; bus.writedata = 32'd10;
    bus.chipselect = 1'b1; bus.write_n = 1'b0;
    for (int k = 0; k <= 33; k++) exp_q.push_back((k % 11 == 0) ? 32'd1 : 32'd0);
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      exp = exp_q.pop_front(); checks++;
      if (dut.pwm_tick !== exp[0]) begin
        errors++; $display("FAIL shrink_tick_k%0d: got %b expected %b", k, dut.pwm_tick, exp[0]);
      end
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_rise();
    test_reversal();
    test_instant();
    test_bypass();
    test_prescale_shrink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
